udp_rx_dispatcher: RTL
======================

Name: udp_rx_dispatcher

Overview:
Receive-side counterpart of the UDP TX arbitration path. Takes the payload byte stream from the UDP protocol stack RX interface and parses a 1-byte type header. It routes the payload to either the LED/seg command consumer or the image receiver, and owns the img_mode register that selects the TX source. It also checks the received byte count against the stack-reported length.

Parameters:
LED_TYPE, 8'hA5, header byte selecting the LED/seg command stream
IMG_TYPE, 8'h5A, header byte selecting the image stream
MODE_TYPE, 8'hC3, header byte for a mode-switch packet

Ports:
clk  in  1  system clock (UDP stack RX clock domain)
rst_n  in  1  asynchronous active-low reset
app_rx_data_valid  in  1  stack payload byte strobe, contiguous per packet
app_rx_data  in  8  stack payload byte
app_rx_data_length  in  16  stack-reported payload length, valid with first byte
led_rx_valid  out  1  LED/seg payload byte valid
led_rx_data  out  8  LED/seg payload byte
led_rx_sop  out  1  first forwarded byte of packet
led_rx_eop  out  1  last forwarded byte of packet
img_rx_valid  out  1  image payload byte valid
img_rx_data  out  8  image payload byte
img_rx_sop  out  1  first forwarded byte
img_rx_eop  out  1  last forwarded byte
rx_len_err  out  1  1-cycle pulse: count mismatch at packet end
img_mode  out  1  0=LED/seg TX source, 1=image TX source

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, including img_mode. FSM in IDLE, hold register empty, byte counter 0.
- Packet framing:
  - A packet is a run of consecutive cycles with app_rx_data_valid=1.
  - The stack guarantees at least 1 idle cycle between packets.
  - A new first byte is accepted in the same cycle the previous packet's end is processed.
- FSM states: IDLE, LED, IMG, MODE, DROP.
  - IDLE + valid: latch app_rx_data_length, set count=1, decode the header byte. LED_TYPE→LED, IMG_TYPE→IMG, MODE_TYPE→MODE, any other value→DROP.
  - LED/IMG/MODE/DROP + valid: count++ (16-bit, saturates at 16'hFFFF).
  - LED/IMG/MODE/DROP + !valid: end of packet, return to IDLE.
- Forwarding (LED/IMG only; the header byte is never forwarded):
  - Each payload byte goes into a 1-deep hold register.
  - The held byte is emitted when the next byte arrives, or with eop=1 when valid drops.
  - Fixed latency: a byte on the input at cycle t is on the output at cycle t+2.
  - sop is set on the first emitted byte. A single-payload-byte packet has sop=eop=1 on the same cycle.
  - A header-only packet (length 1) emits nothing on either output.
  - The LED and IMG outputs are never valid in the same cycle.
- MODE packet:
  - Payload byte 1, bit 0, is captured.
  - At packet end, img_mode takes the captured bit only if count==2 and count==latched length.
  - Otherwise img_mode is unchanged and rx_len_err pulses.
- Length check at every packet end, including DROP: if count != latched length, rx_len_err pulses 1 cycle, aligned with the eop cycle (t+2 of the last byte).
- Data on outputs while valid=0: don't-care. Held at last value for lint cleanliness.
- Reset mid-packet: everything clears immediately. Subsequent bytes of that packet are treated as a new packet, so the first one is decoded as a header.

Optional Feature:
RX_STATS_EN:
- Defined: adds outputs pkt_cnt[15:0] (packets routed to LED/IMG/MODE), drop_cnt[15:0] (DROP packets) and err_cnt[15:0] (rx_len_err pulses).
  - Each counter increments at packet end and wraps at 16'hFFFF→0.
  - Each counter resets to 0.
- Undefined: these ports and counters do not exist. Routing behaviour is identical either way.

Decomposition:
- Package udp_rx_pkg holds:
  - the FSM state enum
  - default type-byte constants (A5/5A/C3)
  - the 16-bit length typedef, shared with the TX side.
- One sub-module is natural: udp_rx_stats, the three saturating-free wrap counters, instantiated only under RX_STATS_EN.

Test Plan:
- Packet A5,11,22,33 with length=4 → led_rx_data 11,22,33 at t+2; sop on 11, eop on 33; img outputs silent; no rx_len_err.
- Packet 5A followed by 1024 incrementing bytes, length=1025 → 1024 img bytes in order, single sop/eop, no gaps.
- Packet C3,01 with length=2 → img_mode 0→1 after end; then C3,00 → back to 0. Packet C3,01,FF with length=3 → img_mode unchanged, rx_len_err pulse.
- Packet 77,AA,BB → nothing forwarded. With RX_STATS_EN, drop_cnt=1.
- Packet A5,11,22 with length=5 → bytes forwarded with eop; rx_len_err pulses on the eop cycle.
- Back-to-back: A5,01 then 1 idle cycle then 5A,02 → LED eop and IMG sop appear correctly. rst_n asserted mid-IMG packet → all outputs 0 immediately, img_mode 0.

Source files
------------

// File: rtl/udp_rx_dispatcher_pkg.sv
// udp_rx_pkg: shared types and constants for the UDP receive dispatcher.
//   - rx_state_e : dispatcher FSM states
//   - len_t      : 16-bit length/counter type, shared with the TX side
//   - default type-header bytes for LED/seg, image and mode-switch packets
package udp_rx_pkg;

  localparam int DATA_W = 8;

  typedef logic [15:0] len_t;

  localparam len_t LEN_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LED,
    ST_IMG,
    ST_MODE,
    ST_DROP
  } rx_state_e;

  localparam logic [DATA_W-1:0] LED_TYPE_DEF  = 8'hA5;
  localparam logic [DATA_W-1:0] IMG_TYPE_DEF  = 8'h5A;
  localparam logic [DATA_W-1:0] MODE_TYPE_DEF = 8'hC3;

endpackage

// File: rtl/udp_rx_dispatcher_if.sv
// udp_rx_dispatcher_if: bundles the stack RX byte stream, the two forwarded
// payload streams, the length-error pulse and the img_mode level.
//   master : the stack/consumer side (drives app_rx_*, observes the rest)
//   slave  : the dispatcher (observes app_rx_*, drives the rest)
// With RX_STATS_EN defined the bundle also carries pkt_cnt, drop_cnt, err_cnt.
interface udp_rx_dispatcher_if;
  import udp_rx_pkg::*;

  logic              app_rx_data_valid;
  logic [DATA_W-1:0] app_rx_data;
  len_t              app_rx_data_length;

  logic              led_rx_valid;
  logic [DATA_W-1:0] led_rx_data;
  logic              led_rx_sop;
  logic              led_rx_eop;

  logic              img_rx_valid;
  logic [DATA_W-1:0] img_rx_data;
  logic              img_rx_sop;
  logic              img_rx_eop;

  logic              rx_len_err;
  logic              img_mode;

`ifdef RX_STATS_EN
  len_t              pkt_cnt;
  len_t              drop_cnt;
  len_t              err_cnt;
`endif

  modport master (
    output app_rx_data_valid, app_rx_data, app_rx_data_length,
    input  led_rx_valid, led_rx_data, led_rx_sop, led_rx_eop,
    input  img_rx_valid, img_rx_data, img_rx_sop, img_rx_eop,
    input  rx_len_err, img_mode
`ifdef RX_STATS_EN
    , input pkt_cnt, drop_cnt, err_cnt
`endif
  );

  modport slave (
    input  app_rx_data_valid, app_rx_data, app_rx_data_length,
    output led_rx_valid, led_rx_data, led_rx_sop, led_rx_eop,
    output img_rx_valid, img_rx_data, img_rx_sop, img_rx_eop,
    output rx_len_err, img_mode
`ifdef RX_STATS_EN
    , output pkt_cnt, drop_cnt, err_cnt
`endif
  );

endinterface

// File: rtl/udp_rx_dispatcher_stats.sv
// udp_rx_stats: three free-running 16-bit event counters (wrap FFFF->0).
//   clk, rst_n : clock, asynchronous active-low reset
//   pkt_inc    : packet routed to LED/IMG/MODE ended this cycle
//   drop_inc   : dropped packet ended this cycle
//   err_inc    : length error detected this cycle
//   pkt_cnt, drop_cnt, err_cnt : counter values
module udp_rx_stats
  import udp_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pkt_inc,
  input  logic drop_inc,
  input  logic err_inc,
  output len_t pkt_cnt,
  output len_t drop_cnt,
  output len_t err_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (pkt_inc)  pkt_cnt  <= pkt_cnt  + 16'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
      if (err_inc)  err_cnt  <= err_cnt  + 16'd1;
    end
  end

endmodule

// File: rtl/udp_rx_dispatcher.sv
// udp_rx_dispatcher: parses the 1-byte type header of each received UDP
// payload and forwards the remaining bytes to the LED/seg or image consumer,
// handles mode-switch packets (img_mode) and flags length mismatches.
//   clk, rst_n : stack RX clock, asynchronous active-low reset
//   rx (slave) : app_rx_* input stream; led_rx_* / img_rx_* output streams
//                with sop/eop; rx_len_err pulse; img_mode level
// Optional build macro RX_STATS_EN adds pkt_cnt/drop_cnt/err_cnt counters.
// Latency: a payload byte at the input in cycle t is on the output in t+2.
module udp_rx_dispatcher
  import udp_rx_pkg::*;
#(
  parameter logic [DATA_W-1:0] LED_TYPE  = LED_TYPE_DEF,
  parameter logic [DATA_W-1:0] IMG_TYPE  = IMG_TYPE_DEF,
  parameter logic [DATA_W-1:0] MODE_TYPE = MODE_TYPE_DEF
) (
  input logic           clk,
  input logic           rst_n,
  udp_rx_dispatcher_if.slave rx
);

  function automatic len_t sat_inc(input len_t v);
    return (v == LEN_MAX) ? v : len_t'(v + 16'd1);
  endfunction

  rx_state_e state_q, state_d;
  len_t      count_q;
  len_t      len_q;
  logic      mode_bit_q;

  logic      hdr_cycle;
  logic      pkt_end;
  logic      fwd_byte;
  logic      len_bad;
  logic      mode_load;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              sop_p0;
  logic              img_p0;

  logic              led_vld_p1, led_sop_p1, led_eop_p1;
  logic              img_vld_p1, img_sop_p1, img_eop_p1;
  logic [DATA_W-1:0] led_data_p1, img_data_p1;
  logic              len_err_p1;
  logic              img_mode_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: header decode in IDLE, any gap in valid ends the packet
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx.app_rx_data_valid) begin
          if (rx.app_rx_data == LED_TYPE)       state_d = ST_LED;
          else if (rx.app_rx_data == IMG_TYPE)  state_d = ST_IMG;
          else if (rx.app_rx_data == MODE_TYPE) state_d = ST_MODE;
          else                                  state_d = ST_DROP;
        end
      end
      default: begin
        if (!rx.app_rx_data_valid) state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    hdr_cycle = (state_q == ST_IDLE) && rx.app_rx_data_valid;
    pkt_end   = (state_q != ST_IDLE) && !rx.app_rx_data_valid;
    fwd_byte  = rx.app_rx_data_valid &&
                ((state_q == ST_LED) || (state_q == ST_IMG));
    // A mode packet is only good with exactly one payload byte, so a length
    // that matches but is not 2 still counts as an error.
    len_bad   = pkt_end && ((count_q != len_q) ||
                ((state_q == ST_MODE) && (count_q != 16'd2)));
    mode_load = pkt_end && (state_q == ST_MODE) && !len_bad;
  end

  // Packet bookkeeping: byte count, latched length, captured mode bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      len_q      <= '0;
      mode_bit_q <= 1'b0;
    end else begin
      if (hdr_cycle) begin
        count_q <= 16'd1;
        len_q   <= rx.app_rx_data_length;
      end else if (rx.app_rx_data_valid) begin
        count_q <= sat_inc(count_q);
      end
      if (rx.app_rx_data_valid && (state_q == ST_MODE) && (count_q == 16'd1))
        mode_bit_q <= rx.app_rx_data[0];
    end
  end

  // Stage p0: one-deep hold register; whether a held byte is the last one is
  // only known a cycle later, from the next input valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sop_p0  <= 1'b0;
      img_p0  <= 1'b0;
    end else begin
      vld_p0 <= fwd_byte;
      if (fwd_byte) begin
        data_p0 <= rx.app_rx_data;
        sop_p0  <= (count_q == 16'd1);
        img_p0  <= (state_q == ST_IMG);
      end
    end
  end

  // Stage p1: output registers; eop and the packet-end results line up here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_vld_p1  <= 1'b0;
      led_sop_p1  <= 1'b0;
      led_eop_p1  <= 1'b0;
      led_data_p1 <= '0;
      img_vld_p1  <= 1'b0;
      img_sop_p1  <= 1'b0;
      img_eop_p1  <= 1'b0;
      img_data_p1 <= '0;
      len_err_p1  <= 1'b0;
      img_mode_q  <= 1'b0;
    end else begin
      led_vld_p1 <= vld_p0 && !img_p0;
      led_sop_p1 <= vld_p0 && !img_p0 && sop_p0;
      led_eop_p1 <= vld_p0 && !img_p0 && !rx.app_rx_data_valid;
      img_vld_p1 <= vld_p0 && img_p0;
      img_sop_p1 <= vld_p0 && img_p0 && sop_p0;
      img_eop_p1 <= vld_p0 && img_p0 && !rx.app_rx_data_valid;
      if (vld_p0 && !img_p0) led_data_p1 <= data_p0;
      if (vld_p0 && img_p0)  img_data_p1 <= data_p0;
      len_err_p1 <= len_bad;
      if (mode_load) img_mode_q <= mode_bit_q;
    end
  end

  assign rx.led_rx_valid = led_vld_p1;
  assign rx.led_rx_data  = led_data_p1;
  assign rx.led_rx_sop   = led_sop_p1;
  assign rx.led_rx_eop   = led_eop_p1;
  assign rx.img_rx_valid = img_vld_p1;
  assign rx.img_rx_data  = img_data_p1;
  assign rx.img_rx_sop   = img_sop_p1;
  assign rx.img_rx_eop   = img_eop_p1;
  assign rx.rx_len_err   = len_err_p1;
  assign rx.img_mode     = img_mode_q;

`ifdef RX_STATS_EN
  logic pkt_inc, drop_inc;

  assign pkt_inc  = pkt_end && (state_q != ST_DROP);
  assign drop_inc = pkt_end && (state_q == ST_DROP);

  udp_rx_stats u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .pkt_inc  (pkt_inc),
    .drop_inc (drop_inc),
    .err_inc  (len_bad),
    .pkt_cnt  (rx.pkt_cnt),
    .drop_cnt (rx.drop_cnt),
    .err_cnt  (rx.err_cnt)
  );
`endif

endmodule
